ps2_rx_frame: RTL and testbench

Synchronous PS/2 device-to-host frame receiver that sits directly upstream of the keyboard scan-code decoder. It samples the raw ps2k_clk / ps2k_data lines in the system clock domain, deglitches the PS/2 clock, and deserialises the 11-bit frame: start, 8 data bits LSB first, odd parity, stop. It delivers each good byte with a one-cycle valid strobe, and flags parity, framing and timeout errors. The decoder therefore never runs logic on the raw PS/2 clock.

---
 rtl/ps2_rx_frame.sv | 179 +++++++++++++++++
 tb/tb_ps2_rx_frame.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver running entirely in the
// system clock domain. Synchronises the raw lines, deglitches the PS/2 clock,
// deserialises start / 8 data (LSB first) / odd parity / stop, and reports
// good bytes (rx_valid) or parity / framing / timeout errors (rx_err).
// Optional feature macro: PS2_RX_TIMEOUT_EN builds the inter-edge timeout.
//
// Handshake: rx_valid and rx_err are single-cycle strobes with no ready
// back-pressure; the consumer must take rx_byte / err_code in the strobe
// cycle (both values are also held until the next event of their kind).
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [1:0] err_code,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

  state_t      state_q, state_d;
  logic        clk_s1, clk_s2, data_s1, data_s2;
  logic        filt, filt_prev;
  logic [7:0]  filt_cnt;
  logic        fall;
  logic        timeout;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic        par_ok;
  logic        valid_d, err_d, load_d;
  logic [1:0]  code_d;

  // Two-flop synchronisers for both raw lines; idle-high reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2k_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2k_data;
      data_s2 <= data_s1;
    end
  end

  // Clock deglitcher: filt only follows after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt      <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= 8'd0;
    end else begin
      filt_prev <= filt;
      if (clk_s2 == filt) begin
        filt_cnt <= 8'd0;
      end else if (filt_cnt == FILT_LAST) begin
        filt     <= ~filt;
        filt_cnt <= 8'd0;
      end else begin
        filt_cnt <= filt_cnt + 8'd1;
      end
    end
  end

  // One-cycle falling-edge event of the filtered clock; data_s2 is the bit for it
  assign fall = filt_prev & ~filt;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;

  // Cycles since the last filtered fall inside a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (fall || state_q == IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // A fall in the same cycle rescues the frame
  assign timeout = (state_q != IDLE) && !fall && (to_cnt == TO_LAST);
`else
  // Without the timeout a stalled frame waits for more edges or reset
  assign timeout = 1'b0;
  wire unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!data_s2) state_d = DATA;
        DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: next values of the strobes, error code and byte load
  always_comb begin
    valid_d = 1'b0;
    err_d   = 1'b0;
    load_d  = 1'b0;
    code_d  = err_code;
    if (timeout) begin
      err_d  = 1'b1;
      code_d = 2'd3;
    end else if (fall && state_q == STOP) begin
      if (!data_s2) begin
        err_d  = 1'b1;
        code_d = 2'd2;
      end else if (par_ok) begin
        valid_d = 1'b1;
        load_d  = 1'b1;
      end else begin
        err_d  = 1'b1;
        code_d = 2'd1;
      end
    end
  end

  // Datapath: shift register, bit count, parity capture and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      par_ok   <= 1'b0;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      err_code <= 2'd0;
    end else begin
      rx_valid <= valid_d;
      rx_err   <= err_d;
      err_code <= code_d;
      if (load_d) rx_byte <= shreg;
      if (fall && !timeout) begin
        case (state_q)
          IDLE: bit_cnt <= 3'd0;
          DATA: begin
            shreg   <= {data_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY:  par_ok <= ^{shreg, data_s2};
          default: ;
        endcase
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: drives PS/2 frames into ps2_rx_frame and checks every
// rx_valid / rx_err strobe against an expected-event queue, including the
// latency from the PS/2 clock falling edge to the strobe.
module tb_ps2_rx_frame;

  localparam int FILT = 8;
  localparam int TO_CYC = 1000;
  localparam int HALF = 40;
  localparam int LAT = FILT + 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2k_clk = 1'b1;
  logic       ps2k_data = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;
  logic [1:0] err_code;
  logic       busy;

  // {kind(1 valid, 2 err), byte or err_code, latency}
  logic [25:0] exp_q[$];

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  int last_fall = 0;
  logic [7:0] last_byte = 8'h00;
  logic [1:0] last_err = 2'd0;
  logic prev_v = 1'b0;
  logic prev_e = 1'b0;

  ps2_rx_frame #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .ps2k_clk(ps2k_clk), .ps2k_data(ps2k_data),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err),
    .err_code(err_code), .busy(busy)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: pop one expectation per strobe
  always @(negedge clk) begin
    logic [25:0] e;
    logic [1:0]  kind;
    if (rst_n && (rx_valid || rx_err)) begin
      chk("excl", {31'd0, rx_valid & rx_err}, 0);
      chk("width", {31'd0, (rx_valid & prev_v) | (rx_err & prev_e)}, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected", {30'd0, rx_valid, rx_err}, 0);
      end else begin
        e = exp_q.pop_front();
        kind = rx_valid ? 2'd1 : 2'd2;
        chk("kind", kind, e[25:24]);
        if (rx_valid) begin
          chk("byte", rx_byte, e[23:16]);
          last_byte = e[23:16];
        end else begin
          chk("code", err_code, e[23:16]);
          chk("held_byte", rx_byte, last_byte);
        end
        chk("latency", cyc - last_fall, e[15:0]);
      end
    end
    prev_v = rx_valid;
    prev_e = rx_err;
  end

  task automatic send_bit(input logic b);
    ps2k_data = b;
    repeat (HALF / 2) @(negedge clk);
    ps2k_clk = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk);
    ps2k_clk = 1'b1;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    if (!s) begin
      exp_q.push_back({2'd2, 8'd2, 16'(LAT)});
      last_err = 2'd2;
    end else if ((^d) ^ p) begin
      exp_q.push_back({2'd1, d, 16'(LAT)});
    end else begin
      exp_q.push_back({2'd2, 8'd1, 16'(LAT)});
      last_err = 2'd1;
    end
    send_bit(1'b0);
    chk("busy_mid", busy, 1);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    drain();
    chk("busy_end", busy, 0);
    chk("err_code_held", err_code, last_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_byte", rx_byte, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_err", rx_err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_busy", busy, 0);
    last_byte = 8'h00;
    last_err = 2'd0;
    exp_q.delete();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b5a;
    logic [7:0] b1c;
    b5a = 8'h5A;
    b1c = 8'h1C;
    do_reset();

    // good, parity error, framing error, recovery
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b1);

    // short idle glitch must not start a frame
    ps2k_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2k_clk = 1'b1;
    for (int i = 0; i < FILT + 8; i++) begin
      @(negedge clk);
      chk("glitch_busy", busy, 0);
    end
    send_frame(8'hAA, 1'b1, 1'b1);

    // stalled frame: start + 4 data bits then no more clocks
`ifdef PS2_RX_TIMEOUT_EN
    exp_q.push_back({2'd2, 8'd3, 16'(TO_CYC + LAT)});
    last_err = 2'd3;
`endif
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b5a[i]);
    for (int i = 0; i < TO_CYC + LAT + 100 && exp_q.size() != 0; i++) @(negedge clk);
`ifdef PS2_RX_TIMEOUT_EN
    drain();
    chk("to_busy", busy, 0);
    chk("to_code", err_code, last_err);
`else
    repeat (TO_CYC + 200) @(negedge clk);
    chk("stall_busy", busy, 1);
    chk("stall_code", err_code, last_err);
    do_reset();
`endif
    send_frame(8'h5A, 1'b1, 1'b1);

    // reset after the 5th data bit
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(b1c[i]);
    do_reset();
    send_frame(8'h1C, 1'b0, 1'b1);

    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
